// File: rtl/pcm_burst_reader.sv
// pcm_burst_reader: one Read Array command, then back-to-back async PCM word reads into an 8-entry show-ahead stream FIFO.
// Latency: first word valid CMD_WAIT+1+REC_WAIT+RD_WAIT cycles after accept, then one word every RD_WAIT+REC_WAIT cycles.
// Backpressure: a full FIFO parks the sequencer between accesses (strobes high); req_ready is high only while idle.
module pcm_burst_reader #(
  parameter int CMD_WAIT = 6,
  parameter int RD_WAIT  = 12,
  parameter int REC_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_len,
  output logic        cs_n,
  output logic        oe_n,
  output logic        we_n,
  output logic        memrst_n,
  output logic [23:0] addr,
  output logic [15:0] data_o,
  output logic        data_oe,
  input  logic [15:0] data_i,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_CMD_HOLD,
    S_CMD_REC,
    S_RD_CHK,
    S_RD,
    S_RD_REC,
    S_DONE
  } state_t;

  localparam logic [15:0] READ_ARRAY_CMD = 16'h00FF;
  // Phase counters are loaded with (length - 1) and the phase ends when they reach zero.
  localparam logic [15:0] CMD_CNT = 16'(CMD_WAIT - 1);
  localparam logic [15:0] RD_CNT  = 16'(RD_WAIT - 1);
  localparam logic [15:0] REC_CNT = 16'(REC_WAIT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  rem_q, rem_d;

  logic        cs_n_q, oe_n_q, we_n_q, data_oe_q;
  logic [15:0] data_o_q;

  logic [15:0] fifo_mem_q [8];
  logic [2:0]  wr_ptr_q, rd_ptr_q;
  logic [3:0]  fifo_cnt_q;
  logic        fifo_full;
  logic        push;
  logic        pop;

  assign fifo_full = (fifo_cnt_q == 4'd8);
  assign rd_valid  = (fifo_cnt_q != 4'd0);
  assign rd_data   = fifo_mem_q[rd_ptr_q];
  assign pop       = rd_valid && rd_ready;

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign memrst_n  = 1'b1;
  assign addr      = addr_q;
  assign cs_n      = cs_n_q;
  assign oe_n      = oe_n_q;
  assign we_n      = we_n_q;
  assign data_oe   = data_oe_q;
  assign data_o    = data_o_q;

  // Sequencer state, phase counter, word address and remaining-word count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic; the read/stall decision is folded into the recovery exits so an unstalled
  // burst spends no cycles in S_RD_CHK, which is only occupied while the FIFO is full.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          rem_d  = req_len;
          if (req_len != 8'd0) begin
            state_d = S_CMD;
            cnt_d   = CMD_CNT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_CMD: begin
        if (cnt_q == 16'd0) begin
          state_d = S_CMD_HOLD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_CMD_HOLD: begin
        state_d = S_CMD_REC;
        cnt_d   = REC_CNT;
      end
      S_CMD_REC: begin
        if (cnt_q == 16'd0) begin
          if (fifo_full) begin
            state_d = S_RD_CHK;
          end else begin
            state_d = S_RD;
            cnt_d   = RD_CNT;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_RD_CHK: begin
        if (!fifo_full) begin
          state_d = S_RD;
          cnt_d   = RD_CNT;
        end
      end
      S_RD: begin
        if (cnt_q == 16'd0) begin
          push    = 1'b1;
          addr_d  = addr_q + 24'd1;
          rem_d   = rem_q - 8'd1;
          state_d = S_RD_REC;
          cnt_d   = REC_CNT;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_RD_REC: begin
        if (cnt_q == 16'd0) begin
          if (rem_q == 8'd0) begin
            state_d = S_DONE;
          end else if (fifo_full) begin
            state_d = S_RD_CHK;
          end else begin
            state_d = S_RD;
            cnt_d   = RD_CNT;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // PCM strobes and data drive are registered from the next state so they line up with state_q
  // and leave the chip glitch-free; data_oe only ever coexists with oe_n high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      data_oe_q <= 1'b0;
      data_o_q  <= '0;
    end else begin
      cs_n_q    <= !(state_d == S_CMD || state_d == S_CMD_HOLD || state_d == S_RD);
      we_n_q    <= (state_d != S_CMD);
      oe_n_q    <= (state_d != S_RD);
      data_oe_q <= (state_d == S_CMD || state_d == S_CMD_HOLD);
      data_o_q  <= (state_d == S_CMD || state_d == S_CMD_HOLD) ? READ_ARRAY_CMD : 16'h0000;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 3'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 3'd1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 4'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 4'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // FIFO storage captures data_i on the edge that ends the read strobe.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: tb/tb_pcm_burst_reader.sv
// tb_pcm_burst_reader: randomized bursts against a PCM memory model and an address/data reference queue.
// Latency: checks first-word, read-spacing and done timing from the accept edge.
// Backpressure: exercises held-off, random and released rd_ready.
module tb_pcm_burst_reader;
  localparam int CMD_WAIT = 6;
  localparam int RD_WAIT  = 12;
  localparam int REC_WAIT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = '0;
  logic [7:0]  req_len = '0;
  logic        cs_n, oe_n, we_n, memrst_n;
  logic [23:0] addr;
  logic [15:0] data_o;
  logic        data_oe;
  logic [15:0] data_i;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic        fixed_mode = 1'b0;
  logic [15:0] fixed_val = 16'h0000;
  logic [15:0] salt = 16'h0000;
  logic        rnd_rdy = 1'b0;
  logic        rdy_force = 1'b0;

  pcm_burst_reader #(.CMD_WAIT(CMD_WAIT), .RD_WAIT(RD_WAIT), .REC_WAIT(REC_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .cs_n(cs_n), .oe_n(oe_n), .we_n(we_n),
    .memrst_n(memrst_n), .addr(addr), .data_o(data_o), .data_oe(data_oe), .data_i(data_i),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: a fixed mixing of the word address with a per-test salt.
  function automatic logic [15:0] mem_word(input logic [23:0] a, input logic [15:0] s);
    return a[15:0] ^ {a[23:16], a[7:0]} ^ s;
  endfunction

  // Memory only drives real data while output-enabled.
  always_comb begin
    data_i = 16'hDEAD;
    if (!oe_n && !cs_n) data_i = fixed_mode ? fixed_val : mem_word(addr, salt);
  end

  // Sole driver of rd_ready.
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      rd_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Bus monitor, sampled mid-cycle.
  int          we_low_cyc = 0, cs_low_cyc = 0, oe_run = 0;
  int          conflict_cnt = 0, bad_width_cnt = 0, bad_cmd_cnt = 0;
  logic        prev_oe = 1'b1, prev_vld = 1'b0;
  logic [23:0] mon_addr[$];
  int          mon_rd_cyc[$];
  logic [15:0] mon_pop[$];
  int          mon_done[$];
  int          mon_vld_rise[$];
  logic [15:0] mon_vld_data[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_oe = 1'b1;
      prev_vld = 1'b0;
      oe_run = 0;
    end else begin
      if (!we_n) begin
        we_low_cyc++;
        if (data_o !== 16'h00FF || data_oe !== 1'b1) bad_cmd_cnt++;
      end
      if (!cs_n) cs_low_cyc++;
      if (data_oe && !oe_n) conflict_cnt++;
      if (!oe_n) begin
        if (prev_oe) begin
          mon_addr.push_back(addr);
          mon_rd_cyc.push_back(cyc);
        end
        oe_run++;
      end else if (!prev_oe) begin
        if (oe_run != RD_WAIT) bad_width_cnt++;
        oe_run = 0;
      end
      prev_oe = oe_n;
      if (rd_valid && !prev_vld) begin
        mon_vld_rise.push_back(cyc);
        mon_vld_data.push_back(rd_data);
      end
      prev_vld = rd_valid;
      if (rd_valid && rd_ready) mon_pop.push_back(rd_data);
      if (done) mon_done.push_back(cyc);
    end
  end

  task automatic clear_mon();
    mon_addr.delete(); mon_rd_cyc.delete(); mon_pop.delete(); mon_done.delete();
    mon_vld_rise.delete(); mon_vld_data.delete();
    we_low_cyc = 0; cs_low_cyc = 0;
  endtask

  task automatic issue_req(input logic [23:0] a, input logic [7:0] n, output int e0);
    @(posedge clk); #2;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL req_ready_before_issue got %b want 1", req_ready);
    end
    req_addr = a; req_len = n; req_valid = 1'b1;
    @(posedge clk); #1;
    e0 = cyc;
    #1;
    req_valid = 1'b0; req_addr = 24'($urandom); req_len = 8'($urandom);
  endtask

  task automatic wait_done(input int bound, input string name);
    int n = 0;
    while (mon_done.size() == 0 && n < bound) begin
      @(posedge clk); n++;
    end
    checks++;
    if (mon_done.size() == 0) begin
      errors++; $display("FAIL %s_done_timeout got none within %0d cycles want a done pulse", name, bound);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cs_n, oe_n, we_n, memrst_n, data_oe, done, busy, rd_valid, req_ready} !== 9'b111100001) begin
      errors++; $display("FAIL reset_ctl got %b want 111100001",
                         {cs_n, oe_n, we_n, memrst_n, data_oe, done, busy, rd_valid, req_ready});
    end
    checks++;
    if ({addr, data_o} !== 40'h0) begin
      errors++; $display("FAIL reset_bus got addr %h data_o %h want 0 0", addr, data_o);
    end
    @(posedge clk); #2; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({cs_n, oe_n, we_n, busy, rd_valid, req_ready} !== 6'b111001) begin
      errors++; $display("FAIL after_reset_idle got %b want 111001", {cs_n, oe_n, we_n, busy, rd_valid, req_ready});
    end
  endtask

  task automatic test_single();
    int e0;
    fixed_mode = 1'b1; fixed_val = 16'h1234; rdy_force = 1'b0;
    repeat (2) @(posedge clk);
    clear_mon();
    issue_req(24'h100000, 8'd1, e0);
    wait_done(100, "single");
    repeat (5) @(posedge clk);
    checks++;
    if (we_low_cyc != CMD_WAIT || bad_cmd_cnt != 0) begin
      errors++; $display("FAIL single_cmd got we_low %0d bad %0d want %0d 0", we_low_cyc, bad_cmd_cnt, CMD_WAIT);
    end
    checks++;
    if (mon_addr.size() != 1 || mon_addr[0] !== 24'h100000 || mon_rd_cyc[0] - e0 != 9) begin
      errors++; $display("FAIL single_read got n=%0d addr %h at %0d want 1 100000 at 9",
                         mon_addr.size(), mon_addr.size() ? mon_addr[0] : 24'h0,
                         mon_rd_cyc.size() ? mon_rd_cyc[0] - e0 : -1);
    end
    checks++;
    if (mon_vld_rise.size() != 1 || mon_vld_rise[0] - e0 != 21 || mon_vld_data[0] !== 16'h1234) begin
      errors++; $display("FAIL single_first_word got n=%0d at %0d data %h want 1 at 21 1234",
                         mon_vld_rise.size(), mon_vld_rise.size() ? mon_vld_rise[0] - e0 : -1,
                         mon_vld_data.size() ? mon_vld_data[0] : 16'h0);
    end
    checks++;
    if (mon_done.size() != 1 || mon_done[0] - e0 != 23) begin
      errors++; $display("FAIL single_done got n=%0d at %0d want 1 at 23",
                         mon_done.size(), mon_done.size() ? mon_done[0] - e0 : -1);
    end
    rdy_force = 1'b1;
    repeat (2) @(posedge clk);
    rdy_force = 1'b0;
    repeat (3) @(posedge clk);
    checks++;
    if (mon_pop.size() != 1 || mon_pop[0] !== 16'h1234 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL single_pop got n=%0d data %h vld %b want 1 1234 0",
                         mon_pop.size(), mon_pop.size() ? mon_pop[0] : 16'h0, rd_valid);
    end
    fixed_mode = 1'b0;
  endtask

  task automatic test_burst4();
    int e0;
    salt = 16'($urandom); rdy_force = 1'b1;
    repeat (2) @(posedge clk);
    clear_mon();
    issue_req(24'h100000, 8'd4, e0);
    wait_done(200, "burst4");
    repeat (4) @(posedge clk);
    checks++;
    if (mon_addr.size() != 4) begin
      errors++; $display("FAIL burst4_nreads got %0d want 4", mon_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (mon_addr[i] !== 24'h100000 + 24'(i) || mon_rd_cyc[i] - e0 != 9 + 14 * i) begin
          errors++; $display("FAIL burst4_read%0d got %h at %0d want %h at %0d",
                             i, mon_addr[i], mon_rd_cyc[i] - e0, 24'h100000 + 24'(i), 9 + 14 * i);
        end
      end
    end
    checks++;
    if (mon_pop.size() != 4) begin
      errors++; $display("FAIL burst4_npop got %0d want 4", mon_pop.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (mon_pop[i] !== mem_word(24'h100000 + 24'(i), salt)) begin
          errors++; $display("FAIL burst4_pop%0d got %h want %h", i, mon_pop[i], mem_word(24'h100000 + 24'(i), salt));
        end
      end
    end
    checks++;
    if (mon_done.size() != 1 || mon_done[0] - e0 != 23 + 14 * 3 || we_low_cyc != CMD_WAIT) begin
      errors++; $display("FAIL burst4_done got n=%0d at %0d we_low %0d want 1 at %0d we_low %0d",
                         mon_done.size(), mon_done.size() ? mon_done[0] - e0 : -1, we_low_cyc, 23 + 42, CMD_WAIT);
    end
    rdy_force = 1'b0;
  endtask

  task automatic test_stall();
    int e0;
    int n = 0;
    logic [23:0] a;
    a = 24'($urandom); salt = 16'($urandom); rdy_force = 1'b0;
    repeat (2) @(posedge clk);
    clear_mon();
    issue_req(a, 8'd12, e0);
    while (mon_addr.size() < 8 && n < 400) begin
      @(posedge clk); n++;
    end
    repeat (40) @(posedge clk);
    @(negedge clk);
    checks++;
    if (mon_addr.size() != 8 || cs_n !== 1'b1 || busy !== 1'b1 || rd_valid !== 1'b1 || mon_done.size() != 0) begin
      errors++; $display("FAIL stall_hold got reads %0d cs_n %b busy %b vld %b done %0d want 8 1 1 1 0",
                         mon_addr.size(), cs_n, busy, rd_valid, mon_done.size());
    end
    rdy_force = 1'b1;
    wait_done(400, "stall");
    repeat (6) @(posedge clk);
    checks++;
    if (mon_addr.size() != 12 || mon_pop.size() != 12) begin
      errors++; $display("FAIL stall_counts got reads %0d pops %0d want 12 12", mon_addr.size(), mon_pop.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (mon_addr[i] !== a + 24'(i) || mon_pop[i] !== mem_word(a + 24'(i), salt)) begin
          errors++; $display("FAIL stall_word%0d got %h/%h want %h/%h",
                             i, mon_addr[i], mon_pop[i], a + 24'(i), mem_word(a + 24'(i), salt));
        end
      end
    end
    rdy_force = 1'b0;
  endtask

  task automatic test_wrap();
    int e0;
    logic [23:0] a;
    a = 24'hFFFFFE; salt = 16'($urandom); rdy_force = 1'b1;
    repeat (2) @(posedge clk);
    clear_mon();
    issue_req(a, 8'd3, e0);
    wait_done(200, "wrap");
    repeat (4) @(posedge clk);
    checks++;
    if (mon_addr.size() != 3 || mon_addr[0] !== 24'hFFFFFE || mon_addr[1] !== 24'hFFFFFF || mon_addr[2] !== 24'h000000) begin
      errors++; $display("FAIL wrap_addr got n=%0d last %h want FFFFFE FFFFFF 000000",
                         mon_addr.size(), mon_addr.size() ? mon_addr[mon_addr.size() - 1] : 24'h0);
    end
    checks++;
    if (mon_pop.size() != 3 || mon_pop[2] !== mem_word(24'h000000, salt) || mon_pop[0] !== mem_word(24'hFFFFFE, salt)) begin
      errors++; $display("FAIL wrap_data got n=%0d want 3 words ending %h", mon_pop.size(), mem_word(24'h0, salt));
    end
    rdy_force = 1'b0;
  endtask

  task automatic test_zero();
    int e0;
    repeat (2) @(posedge clk);
    clear_mon();
    issue_req(24'($urandom), 8'd0, e0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL zero_done got done %b ready %b want 1 0", done, req_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL zero_ready got done %b ready %b want 0 1", done, req_ready);
    end
    repeat (6) @(posedge clk);
    checks++;
    if (cs_low_cyc != 0 || we_low_cyc != 0 || mon_done.size() != 1 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL zero_quiet got cs_low %0d we_low %0d done %0d vld %b want 0 0 1 0",
                         cs_low_cyc, we_low_cyc, mon_done.size(), rd_valid);
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    int n = 0;
    salt = 16'($urandom); rdy_force = 1'b0;
    repeat (2) @(posedge clk);
    clear_mon();
    issue_req(24'($urandom), 8'd4, e0);
    while (mon_addr.size() < 2 && n < 200) begin
      @(posedge clk); n++;
    end
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({cs_n, oe_n, we_n, rd_valid, req_ready, busy, done} !== 7'b1110100) begin
      errors++; $display("FAIL midreset_state got %b want 1110100", {cs_n, oe_n, we_n, rd_valid, req_ready, busy, done});
    end
    @(posedge clk); #2; rst_n = 1'b1;
    repeat (60) @(posedge clk);
    checks++;
    if (mon_done.size() != 0 || mon_addr.size() != 2 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_after got done %0d reads %0d vld %b want 0 2 0",
                         mon_done.size(), mon_addr.size(), rd_valid);
    end
  endtask

  task automatic test_back_to_back();
    int e0;
    logic [23:0] a;
    logic [7:0]  len;
    logic [23:0] exp_addr[$];
    logic [15:0] exp_dat[$];
    salt = 16'($urandom);
    rnd_rdy = 1'b1;
    repeat (2) @(posedge clk);
    clear_mon();
    for (int b = 0; b < 4; b++) begin
      a = 24'($urandom);
      len = 8'($urandom_range(1, 6));
      for (int i = 0; i < int'(len); i++) begin
        exp_addr.push_back(a + 24'(i));
        exp_dat.push_back(mem_word(a + 24'(i), salt));
      end
      issue_req(a, len, e0);
      wait_done(600, "b2b");
      mon_done.delete();
    end
    repeat (80) @(posedge clk);
    rnd_rdy = 1'b0; rdy_force = 1'b1;
    repeat (20) @(posedge clk);
    rdy_force = 1'b0;
    checks++;
    if (mon_addr.size() != exp_addr.size() || mon_pop.size() != exp_dat.size()) begin
      errors++; $display("FAIL b2b_counts got reads %0d pops %0d want %0d %0d",
                         mon_addr.size(), mon_pop.size(), exp_addr.size(), exp_dat.size());
    end else begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        checks++;
        if (mon_addr[i] !== exp_addr[i] || mon_pop[i] !== exp_dat[i]) begin
          errors++; $display("FAIL b2b_word%0d got %h/%h want %h/%h", i, mon_addr[i], mon_pop[i], exp_addr[i], exp_dat[i]);
        end
      end
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (conflict_cnt != 0 || bad_width_cnt != 0 || bad_cmd_cnt != 0 || memrst_n !== 1'b1) begin
      errors++; $display("FAIL invariants got oe_conflict %0d bad_rd_width %0d bad_cmd %0d memrst_n %b want 0 0 0 1",
                         conflict_cnt, bad_width_cnt, bad_cmd_cnt, memrst_n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_burst4();
    test_stall();
    test_wrap();
    test_zero();
    test_reset_mid();
    test_back_to_back();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcm_burst_reader.md
# pcm_burst_reader

Burst read sequencer for the on-board parallel PCM. It accepts a start word address and a word count, issues one Read Array command (0x00FF), then performs back-to-back asynchronous word reads. Read words are pushed into an internal 8-entry FIFO and offered on a valid/ready stream. Downstream consumers are the LED/debug display and future checksum or UART dump stages. The block replaces single-shot command-then-read sequencing with a reusable, back-pressured burst engine.

## Interface
Parameters:
- CMD_WAIT, 6: cycles we_n is held low for the command write (≥1)
- RD_WAIT, 12: cycles cs_n/oe_n are held low per read (≥1)
- REC_WAIT, 2: recovery cycles with cs_n/oe_n/we_n high after each access (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  burst request
- req_ready  out  1  high only in IDLE
- req_addr  in  24  start word address (maps to addr[24:1])
- req_len  in  8  word count; 0 = no access, done pulse only
- cs_n, oe_n, we_n  out  1  PCM strobes, active-low
- memrst_n  out  1  constant 1
- addr  out  24  PCM word address
- data_o  out  16  write data, to the top-level tristate
- data_oe  out  1  drive enable for data_o
- data_i  in  16  PCM read data from the top-level tristate
- rd_data  out  16  FIFO head
- rd_valid  out  1  FIFO not empty
- rd_ready  in  1  consumer pop
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at burst end

## Operation
- Reset values:
  - cs_n, oe_n, we_n, memrst_n = 1
  - data_oe = 0, data_o = 0, addr = 0
  - done = 0, busy = 0, FIFO empty (rd_valid = 0)
  - state = IDLE, so req_ready = 1
- Reset mid-burst: all of the above apply on the next edge, FIFO contents are discarded, and no done pulse is generated.
- A request is accepted on the edge where req_valid && req_ready. At that edge the block latches addr = req_addr and the remaining-word count = req_len.
- State machine:
  - IDLE: on accept, go to CMD if req_len ≠ 0, else go to DONE.
  - CMD: CMD_WAIT cycles with cs_n = 0, we_n = 1→0, oe_n = 1, data_oe = 1, data_o = 0x00FF. Then go to CMD_HOLD.
  - CMD_HOLD: 1 cycle with cs_n = 0, we_n = 1, data still driven. Then go to CMD_REC.
  - CMD_REC: REC_WAIT cycles with all strobes high and data_oe = 0. Then go to RD_CHK.
  - RD_CHK: zero-length decision. Enter RD if the FIFO is not full; otherwise stall with strobes high until a pop frees a slot.
  - RD: RD_WAIT cycles with cs_n = 0, oe_n = 0, we_n = 1, data_oe = 0. On the edge ending the last cycle:
    - data_i is pushed into the FIFO,
    - addr increments by 1,
    - the remaining count decrements.
  - RD_REC: REC_WAIT cycles with strobes high. Then go to RD_CHK if the remaining count ≠ 0, else go to DONE.
  - DONE: done = 1 for one cycle, then IDLE.
- data_oe is never 1 while oe_n = 0.
- Address wrap: 0xFFFFFF + 1 = 0x000000, with no error.
- FIFO is 8 entries, show-ahead: rd_data = head whenever rd_valid.
  - A pop occurs on the edge where rd_valid && rd_ready.
  - A push into a full FIFO cannot occur by construction, because the full check happens before every read and only pops happen during RD.
  - Simultaneous push and pop: the count is unchanged and order is preserved.
  - A pop while empty is ignored.
- The FIFO may still hold data after done; it drains independently and a new request may be accepted while it drains.
- req_valid is ignored while not in IDLE.

## Timing
- With acceptance at edge E0 and defaults (6/12/2):
  - the command occupies E0–E6,
  - the hold occupies E6–E7,
  - recovery occupies E7–E9,
  - the first read occupies E9–E21.
  - rd_valid first rises after E21: latency = CMD_WAIT + 1 + REC_WAIT + RD_WAIT = 21 cycles.
- Without back-pressure, words arrive every RD_WAIT + REC_WAIT = 14 cycles.
- done is high in the cycle after the last RD_REC cycle. For len = N with no stall, done is at cycle 21 + 2 + 14·(N−1) after E0.
- len = 0: done is high in the cycle after E0, with no strobe activity.
- A stall in RD_CHK adds whole cycles. Strobe pulse widths are never shortened.

## Test plan
- Reset, then req_addr = 0x100000, len = 1, memory model returns 0x1234. Required: 0x00FF is driven with we_n low for 6 cycles; rd_valid rises at cycle 21 with rd_data = 0x1234; done pulses once.
- len = 4 from 0x100000 with rd_ready held at 1. Required: addresses 0x100000–0x100003 are read at 14-cycle spacing and four words are popped in order.
- len = 12 with rd_ready = 0. Required: the FIFO fills to 8, the block stalls in RD_CHK with cs_n = 1. After rd_ready = 1, the remaining 4 words are read and no data is lost or duplicated.
- req_addr = 0xFFFFFE, len = 3. Required: addresses are 0xFFFFFE, 0xFFFFFF, 0x000000.
- len = 0. Required: done in the next cycle, no strobe activity, and req_ready returns high one cycle later.
- rst_n low during RD of word 2. Required: strobes high, rd_valid = 0, req_ready = 1 on the next edge, and no done pulse.
